// File: rtl/mem_stage.sv
// Memory pipeline stage: data-memory load/store handshake, load alignment and WB registers.
// Optional branch statistics counters are compiled in with `define MEM_BR_STATS_EN.
`timescale 1ns/1ps

module mem_stage #(
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       mem_pc,
    input  logic [31:0]       mem_alu,
    input  logic [31:0]       mem_rd2,
    input  logic [31:0]       mem_inst,
    input  logic              mem_br_suc,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic [3:0]        dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_rsp_valid,
    input  logic [31:0]       dmem_rdata,
    output logic              mem_stall,
    output logic [31:0]       wb_pc,
    output logic [31:0]       wb_wdata,
    output logic [31:0]       wb_inst,
    output logic              wb_br_suc,
    output logic [31:0]       br_total,
    output logic [31:0]       br_hits
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t      state;
    logic [31:0] load_q;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [1:0]  lane;
    logic        is_load;
    logic        is_store;
    logic        is_jump;
    logic        mem_op;
    logic [3:0]  store_we;
    logic [31:0] store_data;
    logic [31:0] load_ext;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] wdata_sel;
    logic        unused_bits;

    assign opcode   = mem_inst[6:0];
    assign funct3   = mem_inst[14:12];
    assign lane     = mem_alu[1:0];
    assign is_load  = (opcode == 7'b0000011);
    assign is_store = (opcode == 7'b0100011);
    assign is_jump  = (opcode == 7'b1101111) || (opcode == 7'b1100111);
    assign mem_op   = is_load || is_store;

    assign unused_bits = ^{mem_inst[31:15], mem_inst[11:7]};

    // Request fields are combinational from the MEM inputs, which mem_stall keeps stable.
    assign dmem_addr      = {mem_alu[ADDR_W-1:2], 2'b00};
    assign dmem_req_valid = (state == REQ);
    assign dmem_we        = is_store ? store_we : 4'b0000;
    assign dmem_wdata     = store_data;
    assign mem_stall      = mem_op && (state != DONE);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        store_we   = 4'b1111;
        store_data = mem_rd2;
        case (funct3)
            3'b000: begin
                store_we   = 4'b0001 << lane;
                store_data = {4{mem_rd2[7:0]}};
            end
            3'b001: begin
                store_we   = 4'b0011 << {lane[1], 1'b0};
                store_data = {2{mem_rd2[15:0]}};
            end
            default: ;
        endcase
    end

    assign load_byte = dmem_rdata[{lane, 3'b000} +: 8];
    assign load_half = dmem_rdata[{lane[1], 4'b0000} +: 16];

    always_comb begin
        load_ext = dmem_rdata;
        case (funct3)
            3'b000:  load_ext = {{24{load_byte[7]}}, load_byte};
            3'b001:  load_ext = {{16{load_half[15]}}, load_half};
            3'b100:  load_ext = {24'h0, load_byte};
            3'b101:  load_ext = {16'h0, load_half};
            default: load_ext = dmem_rdata;
        endcase
    end

    always_comb begin
        wdata_sel = mem_alu;
        if (is_load)
            wdata_sel = load_q;
        else if (is_jump)
            wdata_sel = mem_pc + 32'd4;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            load_q <= '0;
        end else begin
            case (state)
                IDLE: if (mem_op) state <= REQ;
                REQ:  if (dmem_req_ready) state <= is_load ? RESP : DONE;
                RESP: if (dmem_rsp_valid) begin
                    load_q <= load_ext;
                    state  <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_pc     <= '0;
            wb_wdata  <= '0;
            wb_inst   <= NOP_INST;
            wb_br_suc <= 1'b0;
        end else if (!mem_stall) begin
            wb_pc     <= mem_pc;
            wb_wdata  <= wdata_sel;
            wb_inst   <= mem_inst;
            wb_br_suc <= mem_br_suc;
        end
    end

`ifdef MEM_BR_STATS_EN
    logic [31:0] br_total_q;
    logic [31:0] br_hits_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_total_q <= '0;
            br_hits_q  <= '0;
        end else if (!mem_stall && (opcode == 7'b1100011)) begin
            br_total_q <= br_total_q + 32'd1;
            if (mem_br_suc)
                br_hits_q <= br_hits_q + 32'd1;
        end
    end

    assign br_total = br_total_q;
    assign br_hits  = br_hits_q;
`else
    assign br_total = '0;
    assign br_hits  = '0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a driver pushes expected WB results, a monitor pops them
// whenever the WB registers advance; a small memory model answers with configurable delays.
`timescale 1ns/1ps

module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_pc, mem_alu, mem_rd2, mem_inst;
    logic        mem_br_suc;
    logic        dmem_req_valid, dmem_req_ready;
    logic [3:0]  dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rdata;
    logic        mem_stall;
    logic [31:0] wb_pc, wb_wdata, wb_inst;
    logic        wb_br_suc;
    logic [31:0] br_total, br_hits;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk            (clk),
        .rst            (rst),
        .mem_pc         (mem_pc),
        .mem_alu        (mem_alu),
        .mem_rd2        (mem_rd2),
        .mem_inst       (mem_inst),
        .mem_br_suc     (mem_br_suc),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_ready (dmem_req_ready),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_rsp_valid (dmem_rsp_valid),
        .dmem_rdata     (dmem_rdata),
        .mem_stall      (mem_stall),
        .wb_pc          (wb_pc),
        .wb_wdata       (wb_wdata),
        .wb_inst        (wb_inst),
        .wb_br_suc      (wb_br_suc),
        .br_total       (br_total),
        .br_hits        (br_hits)
    );

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] wdata;
        logic [31:0] inst;
        logic        br;
    } wb_t;

    wb_t sb_q[$];
    int  total = 0;
    int  bad   = 0;

    // Memory model configuration, written by the driver before each instruction.
    int          ready_dly = 0;
    int          rsp_dly   = 1;
    logic [31:0] rdata_cfg = '0;
    bit          stray_rsp = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic summary();
        $display("test done: total=%0d bad=%0d", total, bad);
    endtask

    // Memory model: acts on negedges so the DUT samples stable handshake signals.
    initial begin
        int mem_cnt = 0;
        int rsp_cnt = 0;
        bit hs_sent = 1'b0;
        bit hs_load = 1'b0;
        bit rsp_wait = 1'b0;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        dmem_rdata     = '0;
        forever begin
            @(negedge clk);
            dmem_rsp_valid = 1'b0;
            if (!rst) begin
                dmem_req_ready = 1'b0;
                mem_cnt  = 0;
                hs_sent  = 1'b0;
                rsp_wait = 1'b0;
            end else begin
                if (stray_rsp) begin
                    dmem_rsp_valid = 1'b1;
                    dmem_rdata     = 32'hDEAD_BEEF;
                    stray_rsp      = 1'b0;
                end
                if (hs_sent) begin
                    hs_sent        = 1'b0;
                    dmem_req_ready = 1'b0;
                    mem_cnt        = 0;
                    if (hs_load) begin
                        rsp_wait = 1'b1;
                        rsp_cnt  = 0;
                    end
                end
                if (rsp_wait) begin
                    rsp_cnt++;
                    if (rsp_cnt >= rsp_dly) begin
                        dmem_rsp_valid = 1'b1;
                        dmem_rdata     = rdata_cfg;
                        rsp_wait       = 1'b0;
                    end
                end else if (dmem_req_valid) begin
                    if (mem_cnt >= ready_dly) begin
                        dmem_req_ready = 1'b1;
                        hs_sent        = 1'b1;
                        hs_load        = (dmem_we == 4'b0000);
                    end else begin
                        mem_cnt++;
                    end
                end
            end
        end
    end

    // Monitor: whenever the WB registers advance, compare them with the oldest expectation.
    initial begin
        bit  en;
        wb_t e;
        forever begin
            @(negedge clk);
            en = rst && !mem_stall;
            @(posedge clk);
            #1;
            if (en && rst) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL wb_unexpected: got wb_inst %h expected no update", wb_inst);
                end else begin
                    e = sb_q.pop_front();
                    check({e.name, "_wb_pc"},    wb_pc,            e.pc);
                    check({e.name, "_wb_wdata"}, wb_wdata,         e.wdata);
                    check({e.name, "_wb_inst"},  wb_inst,          e.inst);
                    check({e.name, "_wb_br"},    {31'h0, wb_br_suc}, {31'h0, e.br});
                end
            end
        end
    end

    // Present one instruction in MEM until it retires; check request fields and stall length.
    task automatic issue(input string name, input logic [31:0] pc, input logic [31:0] inst,
                         input logic [31:0] alu, input logic [31:0] rd2, input logic br,
                         input logic [31:0] exp_wdata, input int exp_stall,
                         input int rdy, input int rspd, input logic [31:0] rdata,
                         input logic [31:0] exp_addr, input logic [3:0] exp_we,
                         input logic [31:0] exp_dwdata);
        int stalls = 0;
        bit done   = 1'b0;
        sb_q.push_back('{name, pc, exp_wdata, inst, br});
        mem_pc     = pc;
        mem_inst   = inst;
        mem_alu    = alu;
        mem_rd2    = rd2;
        mem_br_suc = br;
        ready_dly  = rdy;
        rsp_dly    = rspd;
        rdata_cfg  = rdata;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (dmem_req_valid) begin
                check({name, "_addr"}, dmem_addr, exp_addr);
                check({name, "_we"}, {28'h0, dmem_we}, {28'h0, exp_we});
                if (exp_we != 4'b0000)
                    check({name, "_dwdata"}, dmem_wdata, exp_dwdata);
            end
            if (!mem_stall)
                done = 1'b1;
            else
                stalls++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got stall after %0d cycles expected retire", name, stalls);
            summary();
            $finish;
        end
        check({name, "_stall"}, stalls, exp_stall);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b0;
        mem_pc     = '0;
        mem_inst   = 32'h0000_0013;
        mem_alu    = '0;
        mem_rd2    = '0;
        mem_br_suc = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wb_inst",   wb_inst,   32'h0000_0013);
        check("rst_wb_wdata",  wb_wdata,  32'h0);
        check("rst_wb_pc",     wb_pc,     32'h0);
        check("rst_wb_br",     {31'h0, wb_br_suc}, 32'h0);
        check("rst_req_valid", {31'h0, dmem_req_valid}, 32'h0);
        check("rst_br_total",  br_total,  32'h0);
        check("rst_br_hits",   br_hits,   32'h0);
        rst = 1'b1;

        //    name     pc            inst          alu           rd2           br    wdata         stl rdy rsp rdata         addr          we       dwdata
        issue("addi",  32'h10,       32'h00500093, 32'h5,        32'h0,        1'b0, 32'h5,        0,  0,  1,  32'h0,        32'h0,        4'b0000, 32'h0);
        issue("sb",    32'h14,       32'h00000023, 32'h1002,     32'hAB,       1'b0, 32'h1002,     2,  0,  1,  32'h0,        32'h1000,     4'b0100, 32'hABABABAB);
        issue("lb",    32'h18,       32'h00000003, 32'h2003,     32'h0,        1'b0, 32'hFFFFFF80, 5,  0,  3,  32'h80FFFF00, 32'h2000,     4'b0000, 32'h0);
        issue("lhu",   32'h1C,       32'h00005003, 32'h2002,     32'h0,        1'b0, 32'h0000BEEF, 5,  2,  1,  32'hBEEF1234, 32'h2000,     4'b0000, 32'h0);
        issue("jal",   32'h100,      32'h0000006F, 32'h0,        32'h0,        1'b0, 32'h104,      0,  0,  1,  32'h0,        32'h0,        4'b0000, 32'h0);
        issue("jalr",  32'hFFFFFFFC, 32'h00000067, 32'h40,       32'h0,        1'b1, 32'h0,        0,  0,  1,  32'h0,        32'h0,        4'b0000, 32'h0);
        issue("sh",    32'h20,       32'h00001023, 32'h3003,     32'h12345678, 1'b0, 32'h3003,     2,  0,  1,  32'h0,        32'h3000,     4'b1100, 32'h56785678);
        issue("sw",    32'h24,       32'h00002023, 32'h4001,     32'hCAFEBABE, 1'b0, 32'h4001,     2,  0,  1,  32'h0,        32'h4000,     4'b1111, 32'hCAFEBABE);
        issue("lw",    32'h28,       32'h00002003, 32'h5000,     32'h0,        1'b0, 32'h12345678, 3,  0,  1,  32'h12345678, 32'h5000,     4'b0000, 32'h0);
        issue("lh",    32'h2C,       32'h00001003, 32'h5000,     32'h0,        1'b0, 32'hFFFF8001, 3,  0,  1,  32'h00008001, 32'h5000,     4'b0000, 32'h0);
        issue("lbu",   32'h30,       32'h00004003, 32'h5001,     32'h0,        1'b0, 32'h000000F2, 4,  1,  1,  32'h0000F200, 32'h5000,     4'b0000, 32'h0);
        issue("lbpos", 32'h34,       32'h00000003, 32'h5000,     32'h0,        1'b0, 32'h0000007F, 3,  0,  1,  32'h0000007F, 32'h5000,     4'b0000, 32'h0);
        issue("lraw",  32'h38,       32'h00003003, 32'h5002,     32'h0,        1'b0, 32'hA5A50F0F, 3,  0,  1,  32'hA5A50F0F, 32'h5000,     4'b0000, 32'h0);
        issue("beq1",  32'h40,       32'h00000063, 32'h77,       32'h0,        1'b1, 32'h77,       0,  0,  1,  32'h0,        32'h0,        4'b0000, 32'h0);
        issue("beq2",  32'h44,       32'h00000063, 32'h88,       32'h0,        1'b0, 32'h88,       0,  0,  1,  32'h0,        32'h0,        4'b0000, 32'h0);
        issue("beq3",  32'h48,       32'h00000063, 32'h99,       32'h0,        1'b1, 32'h99,       0,  0,  1,  32'h0,        32'h0,        4'b0000, 32'h0);
`ifdef MEM_BR_STATS_EN
        check("br_total", br_total, 32'd3);
        check("br_hits",  br_hits,  32'd2);
`else
        check("br_total", br_total, 32'd0);
        check("br_hits",  br_hits,  32'd0);
`endif

        // Reset in the middle of a request that memory never accepts.
        mem_pc    = 32'h4C;
        mem_inst  = 32'h00002003;
        mem_alu   = 32'h6000;
        ready_dly = 1000;
        repeat (2) @(negedge clk);
        check("mid_req_valid", {31'h0, dmem_req_valid}, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_req_valid", {31'h0, dmem_req_valid}, 32'h0);
        check("mid_rst_wb_inst",   wb_inst,  32'h0000_0013);
        check("mid_rst_wb_wdata",  wb_wdata, 32'h0);
        check("mid_rst_wb_pc",     wb_pc,    32'h0);
        check("mid_rst_br_total",  br_total, 32'h0);
        check("mid_rst_br_hits",   br_hits,  32'h0);
        mem_inst = 32'h0000_0013;
        @(posedge clk);
        #1;
        rst       = 1'b1;
        stray_rsp = 1'b1;
        issue("lw_post", 32'h50,     32'h00002003, 32'h6004,     32'h0,        1'b0, 32'h0BADF00D, 3,  0,  1,  32'h0BADF00D, 32'h6004,     4'b0000, 32'h0);
        issue("addi2",   32'h54,     32'h00A00093, 32'hA,        32'h0,        1'b0, 32'hA,        0,  0,  1,  32'h0,        32'h0,        4'b0000, 32'h0);

        @(negedge clk);
        check("sb_drain", sb_q.size(), 32'h0);
        summary();
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage; consumes mem_pc/mem_alu/mem_rd2/mem_inst/mem_br_suc.
- Performs data-memory loads/stores over a valid/ready request and valid response handshake.
- Aligns and extends load data, selects the writeback value, and registers results into the WB pipeline registers.
- Stalls the upstream pipeline while a memory access is outstanding; wb_wdata feeds the execute-stage WB forwarding path.

Parameters:
- NOP_INST, 32'h0000_0013, instruction value loaded into wb_inst on reset (bubble)
- ADDR_W, 32, data memory address width; dmem_addr is word aligned

Ports:
- clk  in  1  sole clock; all state rises on posedge clk
- rst  in  1  asynchronous, active-low reset
- mem_pc  in  32  PC of instruction in MEM
- mem_alu  in  32  ALU result: effective address or arithmetic result
- mem_rd2  in  32  store data (rs2)
- mem_inst  in  32  instruction in MEM
- mem_br_suc  in  1  branch prediction success flag from EX
- dmem_req_valid  out  1  memory request valid
- dmem_req_ready  in  1  memory accepts request
- dmem_we  out  4  byte write enables; 0 means read
- dmem_addr  out  ADDR_W  word-aligned address, {mem_alu[ADDR_W-1:2],2'b00}
- dmem_wdata  out  32  store data, replicated into lanes
- dmem_rsp_valid  in  1  read data valid
- dmem_rdata  in  32  read data word
- mem_stall  out  1  hold EX/ID/IF and the MEM inputs stable
- wb_pc  out  32  registered PC
- wb_wdata  out  32  registered writeback value
- wb_inst  out  32  registered instruction
- wb_br_suc  out  1  registered branch success flag
- br_total  out  32  resolved-branch count (BR_STATS_EN only)
- br_hits  out  32  correctly predicted count (BR_STATS_EN only)

Behaviour:
- Decode: load = opcode 7'b0000011; store = 7'b0100011; jal/jalr = 7'b1101111 / 7'b1100111. funct3 = inst[14:12].
- FSM states: IDLE, REQ, RESP, DONE.
  - IDLE: mem op present -> REQ. Otherwise stay in IDLE and advance the WB registers this cycle.
  - REQ: dmem_req_valid=1; address, we and wdata are held stable. On dmem_req_ready: load -> RESP, store -> DONE.
  - RESP: on dmem_rsp_valid, capture aligned load data -> DONE.
  - DONE: WB registers update -> IDLE.
- mem_stall = mem op AND state != DONE (combinational). A store with immediate ready stalls 2 cycles; a load with ready and next-cycle rsp stalls 3 cycles.
- dmem_req_valid is asserted only in REQ. dmem_rsp_valid outside RESP is ignored.
- Store enables, where a = mem_alu[1:0]:
  - SB: 4'b0001<<a; wdata = {4{rd2[7:0]}}
  - SH: 4'b0011<<{a[1],1'b0}; wdata = {2{rd2[15:0]}}
  - SW: 4'b1111; wdata = rd2
  - Misaligned low bits are ignored, not trapped.
- Load extract:
  - LB/LBU: byte a, sign- or zero-extended.
  - LH/LHU: half a[1], sign- or zero-extended.
  - LW: full word.
  - Unknown funct3 returns the raw word.
- wb_wdata: load -> extracted data; jal/jalr -> mem_pc+4 (mod 2^32); all others -> mem_alu.
- Reset (any time, including mid-access): state=IDLE, dmem_req_valid=0 immediately, wb_pc=0, wb_wdata=0, wb_inst=NOP_INST, wb_br_suc=0, counters=0. A late response after reset is dropped.
- WB registers hold their value whenever mem_stall=1.

Optional Feature:
- Macro MEM_BR_STATS_EN.
- Defined: br_total increments on each WB register update where mem_inst is a branch (opcode 7'b1100011); br_hits increments additionally when mem_br_suc=1. Both counters wrap at 2^32.
- Undefined: no counter flops; br_total and br_hits are tied to 0.

Test Plan:
- Reset with rst=0 mid-REQ -> dmem_req_valid drops at once; wb_inst=32'h00000013, wb_wdata=0.
- ADDI in MEM, mem_alu=32'h5 -> no stall; next cycle wb_wdata=32'h5.
- SB at mem_alu=32'h1002, rd2=32'hAB, ready held 1 -> dmem_addr=32'h1000, we=4'b0100, wdata=32'hABABABAB; stall for 2 cycles.
- LB at mem_alu=32'h2003, rdata=32'h80FF_FF00 arriving 3 cycles after the request -> wb_wdata=32'hFFFF_FF80; stall covers every wait cycle.
- LHU at mem_alu=32'h2002, rdata=32'hBEEF_1234 with ready delayed 2 cycles -> request held stable; wb_wdata=32'h0000_BEEF.
- JAL at mem_pc=32'h0000_0100 -> wb_wdata=32'h104. With MEM_BR_STATS_EN, 3 branches with mem_br_suc=1,0,1 -> br_total=3, br_hits=2.
